mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters SHALL be: REG_NUM_BITWIDTH, default 5, register-index width; WORD_BITWIDTH, default 32, data/address width (only 32 supported).
REQ-002 Ports SHALL be:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  reset, synchronous, active-low
  in_valid  in  1  EX-side instruction present
  memRead  in  1  load
  memWrite  in  1  store
  memToReg  in  1  writeback selects memory data
  regWrite  in  1  instruction writes register
  funct3  in  3  access size/sign
  ALUresult  in  WORD  effective address / ALU value
  storeData  in  WORD  store source (rs2)
  regToWrite  in  REG_NUM  destination register
  stall  out  1  upstream holds its inputs when high
  dmem_req  out  1  memory request
  dmem_we  out  1  write request
  dmem_addr  out  WORD  word-aligned address
  dmem_wdata  out  WORD  lane-replicated store data
  dmem_wstrb  out  4  byte enables
  dmem_ready  in  1  memory completes request this cycle
  dmem_rdata  in  WORD  read word, valid when dmem_ready
  mem_regWrite, mem_memToReg  out  1  to MEM/WB
  mem_ALUresult, mem_memReadData  out  WORD  to MEM/WB
  mem_regToWrite  out  REG_NUM  to MEM/WB
  fault  out  1  one-cycle pulse: misaligned/illegal access

Function
REQ-003 Block SHALL implement a two-state FSM, IDLE and WAIT; stall = (state==WAIT), combinational.
REQ-004 In IDLE with in_valid=0 at an edge, outputs SHALL become a bubble: mem_regWrite=0, mem_memToReg=0, other MEM outputs 0.
REQ-005 In IDLE, in_valid=1, memRead=memWrite=0: MEM outputs SHALL register inputs next edge (1-cycle latency), mem_memReadData=0, state stays IDLE.
REQ-006 In IDLE, legal memory op: block SHALL latch address, lane data, strobes, control, destination; state->WAIT; MEM outputs bubble.
REQ-007 Legal SHALL mean exactly one of memRead/memWrite, funct3 in {000,001,010,100,101} for loads, {000,001,010} for stores, halfword addr[0]=0, word addr[1:0]=00.
REQ-008 Illegal memory op SHALL pulse fault for exactly one cycle after the edge, produce a bubble, issue no request, stay IDLE.
REQ-009 In WAIT: dmem_req=1, dmem_we=latched memWrite, dmem_addr={addr[31:2],2'b00}; all stable until dmem_ready; in IDLE dmem_req=0, dmem_we=0.
REQ-010 Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; wdata: SB byte replicated x4, SH half replicated x2, SW unchanged.
REQ-011 In WAIT with dmem_ready=0, outputs SHALL be bubble, state stays WAIT, no limit on wait length.
REQ-012 In WAIT with dmem_ready=1: state->IDLE; MEM outputs SHALL load latched regWrite, memToReg, ALUresult, regToWrite; loads capture extracted data, stores mem_memReadData=0.
REQ-013 Load extraction, little-endian lane addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-014 Inputs presented during WAIT (including the completion cycle) SHALL be ignored; the held instruction is accepted on the following IDLE edge.
REQ-015 dmem_ready while IDLE SHALL be ignored.

Reset
REQ-016 rst=0 at a rising edge SHALL force state IDLE, all MEM outputs 0, fault 0, latched registers 0; stall and dmem_req 0 from that edge.
REQ-017 Reset during WAIT SHALL abandon the outstanding request without producing a result; dmem_ready arriving afterward is ignored.

Verification
REQ-018 ALU op, ALUresult=0x1234, regToWrite=5, regWrite=1 -> next cycle mem_ALUresult=0x1234, mem_regToWrite=5, stall never high.
REQ-019 LB addr 0x103, dmem_ready after 3 wait cycles, rdata=0x80FFFFFF -> stall high 4 cycles, mem_memReadData=0xFFFFFF80; LBU same -> 0x00000080.
REQ-020 SH addr 0x202, storeData=0xABCD1234 -> dmem_addr=0x200, wstrb=1100, wdata=0x12341234, we=1, mem_regWrite=0 after completion.
REQ-021 LW addr 0x101 -> fault one cycle, dmem_req never asserted, bubble out, stall 0.
REQ-022 rst=0 mid-WAIT, then dmem_ready=1 -> dmem_req low after edge, all outputs 0, no writeback produced.
REQ-023 Back-to-back LW then ALU op with 0-wait memory -> ALU result emerges exactly one cycle after load result; no instruction lost or duplicated.

Source files
------------

// File: rtl/mem_access.sv
// Memory-stage access unit: decodes load/store size and alignment, holds one request
// until the data memory acknowledges it, then forwards the result to MEM/WB.
module mem_access #(
  parameter int unsigned REG_NUM_BITWIDTH = 5,
  parameter int unsigned WORD_BITWIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        memRead,
  input  logic                        memWrite,
  input  logic                        memToReg,
  input  logic                        regWrite,
  input  logic [2:0]                  funct3,
  input  logic [WORD_BITWIDTH-1:0]    ALUresult,
  input  logic [WORD_BITWIDTH-1:0]    storeData,
  input  logic [REG_NUM_BITWIDTH-1:0] regToWrite,
  output logic                        stall,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [WORD_BITWIDTH-1:0]    dmem_addr,
  output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
  output logic [3:0]                  dmem_wstrb,
  input  logic                        dmem_ready,
  input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
  output logic                        mem_regWrite,
  output logic                        mem_memToReg,
  output logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
  output logic [WORD_BITWIDTH-1:0]    mem_memReadData,
  output logic [REG_NUM_BITWIDTH-1:0] mem_regToWrite,
  output logic                        fault
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e                      state_q;
  logic                        lat_read_q, lat_we_q, lat_regwrite_q, lat_memtoreg_q;
  logic [2:0]                  lat_f3_q;
  logic [1:0]                  lat_off_q;
  logic [WORD_BITWIDTH-1:0]    lat_alu_q, lat_wdata_q;
  logic [3:0]                  lat_wstrb_q;
  logic [REG_NUM_BITWIDTH-1:0] lat_rd_q;

  logic                        mem_regwrite_q, mem_memtoreg_q, fault_q;
  logic [WORD_BITWIDTH-1:0]    mem_alu_q, mem_rdata_q;
  logic [REG_NUM_BITWIDTH-1:0] mem_rd_q;

  logic                        legal;
  logic [1:0]                  off;
  logic [3:0]                  st_wstrb_d;
  logic [WORD_BITWIDTH-1:0]    st_wdata_d, ld_shift, ld_data_d;

  assign off = ALUresult[1:0];

  always_comb begin
    legal      = 1'b0;
    st_wstrb_d = 4'b0000;
    st_wdata_d = storeData;
    if (memRead ^ memWrite) begin
      case (funct3)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~off[0];
        3'b010:  legal = (off == 2'b00);
        3'b100:  legal = memRead;
        3'b101:  legal = memRead & ~off[0];
        default: legal = 1'b0;
      endcase
    end
    if (memWrite) begin
      case (funct3[1:0])
        2'b00: begin
          st_wstrb_d = 4'b0001 << off;
          st_wdata_d = {4{storeData[7:0]}};
        end
        2'b01: begin
          st_wstrb_d = 4'b0011 << off;
          st_wdata_d = {2{storeData[15:0]}};
        end
        default: st_wstrb_d = 4'b1111;
      endcase
    end
  end

  // Little-endian lane select: bring the addressed byte/half down to bit 0.
  assign ld_shift = dmem_rdata >> {lat_off_q, 3'b000};

  always_comb begin
    case (lat_f3_q)
      3'b000:  ld_data_d = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data_d = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data_d = {24'b0, ld_shift[7:0]};
      3'b101:  ld_data_d = {16'b0, ld_shift[15:0]};
      default: ld_data_d = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      lat_read_q     <= 1'b0;
      lat_we_q       <= 1'b0;
      lat_regwrite_q <= 1'b0;
      lat_memtoreg_q <= 1'b0;
      lat_f3_q       <= '0;
      lat_off_q      <= '0;
      lat_alu_q      <= '0;
      lat_wdata_q    <= '0;
      lat_wstrb_q    <= '0;
      lat_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_alu_q      <= '0;
      mem_rdata_q    <= '0;
      mem_rd_q       <= '0;
      fault_q        <= 1'b0;
    end else begin
      // Bubble unless a branch below produces a result this edge.
      fault_q        <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_alu_q      <= '0;
      mem_rdata_q    <= '0;
      mem_rd_q       <= '0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (!memRead && !memWrite) begin
              mem_regwrite_q <= regWrite;
              mem_memtoreg_q <= memToReg;
              mem_alu_q      <= ALUresult;
              mem_rd_q       <= regToWrite;
            end else if (legal) begin
              state_q        <= StWait;
              lat_read_q     <= memRead;
              lat_we_q       <= memWrite;
              lat_regwrite_q <= regWrite;
              lat_memtoreg_q <= memToReg;
              lat_f3_q       <= funct3;
              lat_off_q      <= off;
              lat_alu_q      <= ALUresult;
              lat_wdata_q    <= st_wdata_d;
              lat_wstrb_q    <= st_wstrb_d;
              lat_rd_q       <= regToWrite;
            end else begin
              fault_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (dmem_ready) begin
            state_q        <= StIdle;
            mem_regwrite_q <= lat_regwrite_q;
            mem_memtoreg_q <= lat_memtoreg_q;
            mem_alu_q      <= lat_alu_q;
            mem_rd_q       <= lat_rd_q;
            mem_rdata_q    <= lat_read_q ? ld_data_d : '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall           = (state_q == StWait);
  assign dmem_req        = (state_q == StWait);
  assign dmem_we         = (state_q == StWait) & lat_we_q;
  assign dmem_addr       = {lat_alu_q[WORD_BITWIDTH-1:2], 2'b00};
  assign dmem_wdata      = lat_wdata_q;
  assign dmem_wstrb      = lat_wstrb_q;
  assign mem_regWrite    = mem_regwrite_q;
  assign mem_memToReg    = mem_memtoreg_q;
  assign mem_ALUresult   = mem_alu_q;
  assign mem_memReadData = mem_rdata_q;
  assign mem_regToWrite  = mem_rd_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, hand sequences for reset/back-to-back,
// and random transactions checked against a size/alignment model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst, in_valid, memRead, memWrite, memToReg, regWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUresult, storeData;
  logic [4:0]  regToWrite;
  logic        stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_regWrite, mem_memToReg, fault;
  logic [31:0] mem_ALUresult, mem_memReadData;
  logic [4:0]  mem_regToWrite;

  int n_pass  = 0;
  int n_total = 0;

  mem_access dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .memRead        (memRead),
    .memWrite       (memWrite),
    .memToReg       (memToReg),
    .regWrite       (regWrite),
    .funct3         (funct3),
    .ALUresult      (ALUresult),
    .storeData      (storeData),
    .regToWrite     (regToWrite),
    .stall          (stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .mem_regWrite   (mem_regWrite),
    .mem_memToReg   (mem_memToReg),
    .mem_ALUresult  (mem_ALUresult),
    .mem_memReadData(mem_memReadData),
    .mem_regToWrite (mem_regToWrite),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: access size from funct3, alignment by modulo, lanes by byte arithmetic.
  task automatic m_model(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdata, output bit flt, output logic [3:0] strb,
                         output logic [31:0] wdata, output logic [31:0] data);
    int size;
    int offs;
    logic [31:0] v, mask;
    flt = 1'b0; strb = 4'h0; wdata = 32'h0; data = 32'h0;
    offs = int'(addr % 4);
    if (!rd && !wr) return;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    if (rd && wr) begin flt = 1'b1; return; end
    if (size == 0 || (wr && f3[2]) || (f3[2] && size == 4)) begin flt = 1'b1; return; end
    if ((offs % size) != 0) begin flt = 1'b1; return; end
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        wdata = wdata | (((sd >> (8 * (i % size))) & 32'hFF) << (8 * i));
        if (i >= offs && i < offs + size) strb[i] = 1'b1;
      end
    end else begin
      mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      v = (rdata >> (8 * offs)) & mask;
      if (!f3[2] && size < 4 && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
      data = v;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid   = 1'b0;
    dmem_ready = 1'($urandom % 2);
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    chk("idle_regwrite", {31'b0, mem_regWrite}, 32'h0);
    chk("idle_alu", mem_ALUresult, 32'h0);
    chk("idle_stall", {31'b0, stall}, 32'h0);
    chk("idle_req", {31'b0, dmem_req}, 32'h0);
    chk("idle_fault", {31'b0, fault}, 32'h0);
  endtask

  task automatic do_instr(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input int waits, input bit rw,
                          input bit m2r, input logic [4:0] rdst, input bit e_fault,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_data);
    @(negedge clk);
    in_valid = 1'b1; memRead = rd; memWrite = wr; funct3 = f3; ALUresult = addr;
    storeData = sd; regWrite = rw; memToReg = m2r; regToWrite = rdst;
    dmem_ready = 1'($urandom % 2);
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    if (!rd && !wr) begin
      chk("alu_stall", {31'b0, stall}, 32'h0);
      chk("alu_req", {31'b0, dmem_req}, 32'h0);
      chk("alu_fault", {31'b0, fault}, 32'h0);
      chk("alu_regwrite", {31'b0, mem_regWrite}, {31'b0, rw});
      chk("alu_memtoreg", {31'b0, mem_memToReg}, {31'b0, m2r});
      chk("alu_result", mem_ALUresult, addr);
      chk("alu_rd", {27'b0, mem_regToWrite}, {27'b0, rdst});
      chk("alu_rdata", mem_memReadData, 32'h0);
    end else if (e_fault) begin
      chk("flt_fault", {31'b0, fault}, 32'h1);
      chk("flt_stall", {31'b0, stall}, 32'h0);
      chk("flt_req", {31'b0, dmem_req}, 32'h0);
      chk("flt_regwrite", {31'b0, mem_regWrite}, 32'h0);
      chk("flt_alu", mem_ALUresult, 32'h0);
    end else begin
      chk("acc_fault", {31'b0, fault}, 32'h0);
      chk("acc_bubble", {31'b0, mem_regWrite}, 32'h0);
      for (int w = 0; w <= waits; w++) begin
        chk("wait_stall", {31'b0, stall}, 32'h1);
        chk("wait_req", {31'b0, dmem_req}, 32'h1);
        chk("wait_we", {31'b0, dmem_we}, {31'b0, wr});
        chk("wait_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("wait_out_bubble", {31'b0, mem_regWrite}, 32'h0);
        if (wr) begin
          chk("wait_wstrb", {28'b0, dmem_wstrb}, {28'b0, e_strb});
          chk("wait_wdata", dmem_wdata, e_wdata);
        end
        @(negedge clk);
        // Scramble upstream inputs: the unit must ignore them while waiting.
        in_valid = 1'($urandom % 2); memRead = 1'($urandom % 2); memWrite = 1'($urandom % 2);
        funct3 = 3'($urandom); ALUresult = $urandom; storeData = $urandom;
        regWrite = 1'($urandom % 2); regToWrite = 5'($urandom);
        dmem_ready = (w == waits);
        dmem_rdata = (w == waits) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      chk("done_stall", {31'b0, stall}, 32'h0);
      chk("done_req", {31'b0, dmem_req}, 32'h0);
      chk("done_regwrite", {31'b0, mem_regWrite}, {31'b0, rw});
      chk("done_memtoreg", {31'b0, mem_memToReg}, {31'b0, m2r});
      chk("done_alu", mem_ALUresult, addr);
      chk("done_rd", {27'b0, mem_regToWrite}, {27'b0, rdst});
      chk("done_rdata", mem_memReadData, e_data);
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          waits;
    bit          flt;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] data;
  } vec_t;

  initial begin
    vec_t tbl[$];
    bit          flt;
    logic [3:0]  strb;
    logic [31:0] wdata, data, addr, sd, rdata;
    bit          rd, wr;
    logic [2:0]  f3;

    tbl.push_back('{1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 3, 0, 4'h0, 32'h0, 32'hFFFFFF80});
    tbl.push_back('{1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 3, 0, 4'h0, 32'h0, 32'h00000080});
    tbl.push_back('{0, 1, 3'b001, 32'h202, 32'hABCD1234, 32'h0, 1, 0, 4'hC, 32'h12341234, 32'h0});
    tbl.push_back('{1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 2, 0, 4'h0, 32'h0, 32'hFFFF8001});
    tbl.push_back('{1, 0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 0, 0, 4'h0, 32'h0, 32'h00008001});
    tbl.push_back('{0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0, 0, 4'h2, 32'hA5A5A5A5, 32'h0});
    tbl.push_back('{0, 1, 3'b010, 32'h400, 32'h11223344, 32'h0, 2, 0, 4'hF, 32'h11223344, 32'h0});
    tbl.push_back('{1, 0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 1, 0, 4'h0, 32'h0, 32'h0000007F});
    tbl.push_back('{1, 0, 3'b000, 32'h102, 32'h0, 32'h12345678, 0, 0, 4'h0, 32'h0, 32'h00000034});
    tbl.push_back('{1, 0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1, 0, 3'b101, 32'h101, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{0, 1, 3'b001, 32'h201, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1, 0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0});

    rst = 1'b0; in_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; memToReg = 1'b0;
    regWrite = 1'b0; funct3 = 3'b0; ALUresult = 32'h0; storeData = 32'h0; regToWrite = 5'h0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_regwrite", {31'b0, mem_regWrite}, 32'h0);
    chk("rst_alu", mem_ALUresult, 32'h0);
    chk("rst_rdata", mem_memReadData, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();

    // Plain ALU op passes straight through in one cycle.
    do_instr(0, 0, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 1, 0, 5'd5, 0, 4'h0, 32'h0, 32'h0);
    idle_cycle();

    foreach (tbl[i]) begin
      do_instr(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].sd, tbl[i].rdata,
               tbl[i].waits, tbl[i].rd, tbl[i].rd, 5'(i + 1), tbl[i].flt, tbl[i].strb,
               tbl[i].wdata, tbl[i].data);
    end
    idle_cycle();

    // Back-to-back: zero-wait load, then ALU op lands exactly one cycle after the load result.
    do_instr(1, 0, 3'b010, 32'h600, 32'h0, 32'hCAFEF00D, 0, 1, 1, 5'd7, 0, 4'h0, 32'h0,
             32'hCAFEF00D);
    do_instr(0, 0, 3'b000, 32'h0BAD, 32'h0, 32'h0, 0, 1, 0, 5'd8, 0, 4'h0, 32'h0, 32'h0);
    idle_cycle();

    // Reset during a wait abandons the request; a late ready produces nothing.
    @(negedge clk);
    in_valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; ALUresult = 32'h500;
    regWrite = 1'b1; memToReg = 1'b1; regToWrite = 5'd9; dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rw_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rw_req", {31'b0, dmem_req}, 32'h0);
    chk("rw_stall0", {31'b0, stall}, 32'h0);
    chk("rw_regwrite", {31'b0, mem_regWrite}, 32'h0);
    @(negedge clk);
    rst = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h55AA55AA;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rw_late_regwrite", {31'b0, mem_regWrite}, 32'h0);
      chk("rw_late_rdata", mem_memReadData, 32'h0);
      chk("rw_late_alu", mem_ALUresult, 32'h0);
      chk("rw_late_req", {31'b0, dmem_req}, 32'h0);
    end

    // Reset clears a registered ALU result.
    do_instr(0, 0, 3'b000, 32'h7777, 32'h0, 32'h0, 0, 1, 1, 5'd3, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_clr_alu", mem_ALUresult, 32'h0);
    chk("rst_clr_regwrite", {31'b0, mem_regWrite}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 200; n++) begin
      if ($urandom % 4 == 0) begin
        rd = 1'b0; wr = 1'b0;
      end else if ($urandom % 16 == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else begin
        rd = 1'($urandom % 2); wr = ~rd;
      end
      f3 = 3'($urandom); addr = $urandom; sd = $urandom; rdata = $urandom;
      m_model(rd, wr, f3, addr, sd, rdata, flt, strb, wdata, data);
      do_instr(rd, wr, f3, addr, sd, rdata, int'($urandom % 4), 1'($urandom % 2),
               1'($urandom % 2), 5'($urandom), flt, strb, wdata, data);
      if ($urandom % 5 == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
